// File: rtl/obstacle_row_streamer.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_row_streamer
// Purpose  : Double-buffers complete obstacle bitmaps and, on a solver
//            request, streams the active image out one row per handshake.
//            Images arriving mid-frame wait in a pending buffer and are
//            promoted only at frame end, so a frame is never torn.
// Revision : 1.0 - initial release
// ============================================================================
module obstacle_row_streamer #(
    parameter int GRID_W = 50,
    parameter int GRID_H = 50
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     img_valid,
    input  logic [GRID_W*GRID_H-1:0] img_data,
    input  logic                     frame_start,
    input  logic                     row_ready,
    output logic                     row_valid,
    output logic [GRID_W-1:0]        row_data,
    output logic [5:0]               row_idx,
    output logic                     frame_done,
    output logic                     img_loaded,
    output logic                     overrun
);

    localparam int         c_IMG_W    = GRID_W * GRID_H;
    localparam logic [5:0] c_LAST_ROW = 6'(GRID_H - 1);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_STREAM = 2'd1;
    localparam logic [1:0] c_S_DONE   = 2'd2;

    logic [1:0]         r_state;
    logic [c_IMG_W-1:0] r_active;
    logic [c_IMG_W-1:0] r_pending;
    logic               r_pend_full;
    logic               r_row_valid;
    logic [GRID_W-1:0]  r_row_data;
    logic [5:0]         r_row_idx;
    logic               r_frame_done;
    logic               r_img_loaded;
    logic               r_overrun;

    logic [GRID_W-1:0]  w_rows [GRID_H];
    logic [GRID_W-1:0]  w_img_row0;
    logic [5:0]         w_next_idx;
    logic               w_beat;

    // Row r of the active image is the r-th 50-bit slice counted from the MSB
    for (genvar g = 0; g < GRID_H; g++) begin : g_rows
        assign w_rows[g] = r_active[c_IMG_W-1-GRID_W*g -: GRID_W];
    end

    // Row 0 of an image arriving together with frame_start (new image wins)
    assign w_img_row0 = img_data[c_IMG_W-1 -: GRID_W];
    assign w_next_idx = r_row_idx + 6'd1;
    assign w_beat     = r_row_valid & row_ready;

    // Frame sequencer: buffer management, row counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_S_IDLE;
            r_active     <= '0;
            r_pending    <= '0;
            r_pend_full  <= 1'b0;
            r_row_valid  <= 1'b0;
            r_row_data   <= '0;
            r_row_idx    <= '0;
            r_frame_done <= 1'b0;
            r_img_loaded <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (img_valid) begin
                        r_active     <= img_data;
                        r_img_loaded <= 1'b1;
                    end
                    // A request with no image anywhere is silently dropped
                    if (frame_start && (r_img_loaded || img_valid)) begin
                        r_state     <= c_S_STREAM;
                        r_row_idx   <= '0;
                        r_row_valid <= 1'b1;
                        r_row_data  <= img_valid ? w_img_row0 : w_rows[0];
                    end
                end
                c_S_STREAM: begin
                    // Newest image always kept; losing an unpromoted one is flagged
                    if (img_valid) begin
                        r_pending   <= img_data;
                        r_pend_full <= 1'b1;
                        if (r_pend_full) begin
                            r_overrun <= 1'b1;
                        end
                    end
                    if (w_beat) begin
                        if (r_row_idx == c_LAST_ROW) begin
                            r_state      <= c_S_DONE;
                            r_row_valid  <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_row_idx  <= w_next_idx;
                            r_row_data <= w_rows[w_next_idx];
                        end
                    end
                end
                c_S_DONE: begin
                    // Promotion point; an image arriving now supersedes pending
                    if (img_valid) begin
                        r_active     <= img_data;
                        r_img_loaded <= 1'b1;
                        if (r_pend_full) begin
                            r_overrun <= 1'b1;
                        end
                    end else if (r_pend_full) begin
                        r_active <= r_pending;
                    end
                    r_pend_full <= 1'b0;
                    r_state     <= c_S_IDLE;
                end
                default: begin
                    r_state     <= c_S_IDLE;
                    r_row_valid <= 1'b0;
                end
            endcase
        end
    end

    assign row_valid  = r_row_valid;
    assign row_data   = r_row_data;
    assign row_idx    = r_row_idx;
    assign frame_done = r_frame_done;
    assign img_loaded = r_img_loaded;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_row_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_obstacle_row_streamer
// Purpose  : Directed self-checking bench for obstacle_row_streamer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obstacle_row_streamer;

    logic          clk;
    logic          rst_n;
    logic          img_valid;
    logic [2499:0] img_data;
    logic          frame_start;
    logic          row_ready;
    logic          row_valid;
    logic [49:0]   row_data;
    logic [5:0]    row_idx;
    logic          frame_done;
    logic          img_loaded;
    logic          overrun;

    int n_total = 0;
    int n_bad   = 0;

    obstacle_row_streamer #(.GRID_W(50), .GRID_H(50)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .img_valid   (img_valid),
        .img_data    (img_data),
        .frame_start (frame_start),
        .row_ready   (row_ready),
        .row_valid   (row_valid),
        .row_data    (row_data),
        .row_idx     (row_idx),
        .frame_done  (frame_done),
        .img_loaded  (img_loaded),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Image whose row r holds the value r+off
    function automatic logic [2499:0] make_img(input int off);
        logic [2499:0] v;
        v = '0;
        for (int r = 0; r < 50; r++) begin
            v[2499-50*r -: 50] = 50'(r + off);
        end
        return v;
    endfunction

    // Request a frame and follow it to frame_done; optional image pulses at given rows
    task automatic run_frame(input string tag, input int off, input bit toggle,
                             input int inj1_row, input int inj1_off,
                             input int inj2_row, input int inj2_off);
        int cnt;
        int cyc;
        bit done;
        bit inj1;
        bit inj2;
        frame_start = 1'b1;
        row_ready   = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        cnt = 0; cyc = 0; done = 1'b0; inj1 = 1'b0; inj2 = 1'b0;
        while (!done && cyc < 300) begin
            row_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (!inj1 && inj1_row >= 0 && cnt == inj1_row) begin
                img_data  = make_img(inj1_off);
                img_valid = 1'b1;
                inj1      = 1'b1;
            end else if (!inj2 && inj2_row >= 0 && cnt == inj2_row) begin
                img_data  = make_img(inj2_off);
                img_valid = 1'b1;
                inj2      = 1'b1;
            end
            @(negedge clk);
            if (frame_done) begin
                done = 1'b1;
                check_eq({tag, "_beats"}, 64'(cnt), 64'd50);
                check_eq({tag, "_valid_at_done"}, 64'(row_valid), 64'd0);
                if (!toggle) check_eq({tag, "_done_cycle"}, 64'(cyc), 64'd50);
            end else begin
                check_eq({tag, "_valid"}, 64'(row_valid), 64'd1);
                check_eq({tag, "_idx"}, 64'(row_idx), 64'(cnt));
                check_eq({tag, "_data"}, 64'(row_data), 64'(cnt + off));
                if (row_ready) cnt++;
            end
            @(posedge clk); #1;
            img_valid = 1'b0;
            cyc++;
        end
        check_eq({tag, "_done_seen"}, 64'(done), 64'd1);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 64'(frame_done), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin : main
        logic [2499:0] bitimg;
        bit            seen49;
        bit            done;
        rst_n = 1'b0; img_valid = 1'b0; img_data = '0;
        frame_start = 1'b0; row_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_row_valid",  64'(row_valid),  64'd0);
        check_eq("rst_row_data",   64'(row_data),   64'd0);
        check_eq("rst_row_idx",    64'(row_idx),    64'd0);
        check_eq("rst_frame_done", 64'(frame_done), 64'd0);
        check_eq("rst_img_loaded", 64'(img_loaded), 64'd0);
        check_eq("rst_overrun",    64'(overrun),    64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // frame_start with no image is ignored
        frame_start = 1'b1; row_ready = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("noimg_valid", 64'(row_valid),  64'd0);
            check_eq("noimg_done",  64'(frame_done), 64'd0);
        end
        @(posedge clk); #1;

        // Load image A (row r = r)
        img_data = make_img(0); img_valid = 1'b1;
        @(posedge clk); #1;
        img_valid = 1'b0;
        @(negedge clk);
        check_eq("load_img_loaded", 64'(img_loaded), 64'd1);
        @(posedge clk); #1;

        run_frame("fullrate", 0, 1'b0, -1, 0, -1, 0);
        run_frame("toggle",   0, 1'b1, -1, 0, -1, 0);

        // B arrives at row 10: A finishes, B streams next
        run_frame("a_with_b", 0, 1'b0, 10, 100, -1, 0);
        check_eq("ovr_after_b", 64'(overrun), 64'd0);
        run_frame("b_frame", 100, 1'b0, -1, 0, -1, 0);
        check_eq("ovr_b_frame", 64'(overrun), 64'd0);

        // Two images in one frame: newest streams next, overrun sticks
        run_frame("b_with_cd", 100, 1'b0, 10, 200, 20, 300);
        check_eq("ovr_set", 64'(overrun), 64'd1);
        run_frame("d_frame", 300, 1'b0, -1, 0, -1, 0);
        check_eq("ovr_sticky", 64'(overrun), 64'd1);

        // Same-cycle image + request streams the new image; bit ordering
        bitimg = '0;
        bitimg[2499] = 1'b1;
        bitimg[2450] = 1'b1;
        bitimg[0]    = 1'b1;
        img_data = bitimg; img_valid = 1'b1; frame_start = 1'b1; row_ready = 1'b1;
        @(posedge clk); #1;
        img_valid = 1'b0; frame_start = 1'b0;
        @(negedge clk);
        check_eq("bit_row0_idx",  64'(row_idx),  64'd0);
        check_eq("bit_row0_data", 64'(row_data), 64'h2000000000001);
        seen49 = 1'b0; done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (row_valid && row_idx == 6'd49) begin
                seen49 = 1'b1;
                check_eq("bit_row49_data", 64'(row_data), 64'd1);
            end
            if (row_valid && row_idx == 6'd1)
                check_eq("bit_row1_data", 64'(row_data), 64'd0);
            if (frame_done) done = 1'b1;
        end
        check_eq("bit_seen49", 64'(seen49), 64'd1);
        check_eq("bit_done",   64'(done),   64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset mid-frame at row 25
        frame_start = 1'b1; row_ready = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        for (int c = 0; c < 100 && row_idx != 6'd25; c++) begin
            @(posedge clk); #1;
        end
        check_eq("mid_reach25", 64'(row_idx), 64'd25);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_row_valid",  64'(row_valid),  64'd0);
        check_eq("async_row_data",   64'(row_data),   64'd0);
        check_eq("async_row_idx",    64'(row_idx),    64'd0);
        check_eq("async_img_loaded", 64'(img_loaded), 64'd0);
        check_eq("async_overrun",    64'(overrun),    64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("postrst_valid", 64'(row_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Recovery with a fresh image
        img_data = make_img(400); img_valid = 1'b1;
        @(posedge clk); #1;
        img_valid = 1'b0;
        run_frame("recover", 400, 1'b0, -1, 0, -1, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
